// File: rtl/pixel_shifter.sv
// pixel_shifter: double-buffered serializer turning 16-bit line-buffer words
// into pixel indices at dot rate, with per-pixel stretch and sticky
// underrun/overrun flags.
//
// Handshake: the fetch stage may pulse load_i at any edge. A load is accepted
// when the holding register is empty, or when it is being handed to the
// shifter on the same edge. A load that is not accepted is dropped and raises
// overrun_o. word_req_o pulses for one cycle right after a transfer has left
// the holding register empty. It is the cue to supply the next word within
// one word-time.
module pixel_shifter #(
  parameter int WORD_W = 16,
  parameter int PIX_W  = 8
) (
  input  logic              dotclk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [1:0]        depth_i,
  input  logic [1:0]        stretch_i,
  input  logic              blank_i,
  input  logic              flag_clr_i,
  output logic [PIX_W-1:0]  pix_o,
  output logic              pix_valid_o,
  output logic              word_req_o,
  output logic              underrun_o,
  output logic              overrun_o
);

  logic [WORD_W-1:0] hold_q;
  logic              hold_full_q;
  logic [WORD_W-1:0] shift_q;
  logic [4:0]        cnt_q;       // pixels left in the shifter, including the one shown
  logic [1:0]        rep_q;       // repeats left for the current pixel
  logic [1:0]        str_q;       // stretch latched at transfer
  logic [1:0]        dep_q;       // depth latched at transfer
  logic              word_req_q;
  logic              underrun_q;
  logic              overrun_q;

  logic              last_rep;
  logic              finishing;
  logic              xfer;
  logic              hold_write;
  logic              underrun_set;
  logic              overrun_set;
  logic [WORD_W-1:0] shifted;
  logic [PIX_W-1:0]  pix_raw;

  function automatic logic [4:0] pix_per_word(input logic [1:0] d);
    case (d)
      2'b00:   return 5'd16;
      2'b01:   return 5'd8;
      2'b10:   return 5'd4;
      default: return 5'd2;
    endcase
  endfunction

  // Decide this edge's transfer, shift and flag events.
  always_comb begin
    last_rep     = (rep_q == 2'd0);
    finishing    = (cnt_q == 5'd0) || ((cnt_q == 5'd1) && last_rep);
    xfer         = !blank_i && hold_full_q && finishing;
    hold_write   = !blank_i && load_i && (!hold_full_q || xfer);
    underrun_set = !blank_i && !hold_full_q && (cnt_q == 5'd1) && last_rep;
    overrun_set  = !blank_i && load_i && hold_full_q && !xfer;
  end

  // Shift-left by the latched bits-per-pixel, and MSB-first pixel extraction.
  always_comb begin
    shifted = shift_q;
    pix_raw = '0;
    case (dep_q)
      2'b00: begin
        shifted    = shift_q << 1;
        pix_raw[0] = shift_q[WORD_W-1];
      end
      2'b01: begin
        shifted      = shift_q << 2;
        pix_raw[1:0] = shift_q[WORD_W-1 -: 2];
      end
      2'b10: begin
        shifted      = shift_q << 4;
        pix_raw[3:0] = shift_q[WORD_W-1 -: 4];
      end
      default: begin
        shifted      = shift_q << 8;
        pix_raw[7:0] = shift_q[WORD_W-1 -: 8];
      end
    endcase
  end

  // Holding register: accept loads, empty on transfer, flush on blank.
  always_ff @(posedge dotclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (blank_i) begin
      hold_full_q <= 1'b0;
    end else if (hold_write) begin
      hold_q      <= data_i;
      hold_full_q <= 1'b1;
    end else if (xfer) begin
      hold_full_q <= 1'b0;
    end
  end

  // Shift register: reload on transfer, otherwise repeat, shift or drain.
  always_ff @(posedge dotclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      str_q   <= '0;
      dep_q   <= '0;
    end else if (blank_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
    end else if (xfer) begin
      shift_q <= hold_q;
      cnt_q   <= pix_per_word(depth_i);
      rep_q   <= stretch_i;
      str_q   <= stretch_i;
      dep_q   <= depth_i;
    end else if (cnt_q != 5'd0) begin
      if (!last_rep) begin
        rep_q <= rep_q - 2'd1;
      end else if (cnt_q != 5'd1) begin
        shift_q <= shifted;
        cnt_q   <= cnt_q - 5'd1;
        rep_q   <= str_q;
      end else begin
        shift_q <= '0;
        cnt_q   <= 5'd0;
      end
    end
  end

  // Word request: one cycle after a transfer that leaves the hold empty.
  always_ff @(posedge dotclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_req_q <= 1'b0;
    end else begin
      word_req_q <= xfer && !load_i;
    end
  end

  // Sticky flags: a set event on the same edge beats a clear.
  always_ff @(posedge dotclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      underrun_q <= underrun_set || (underrun_q && !flag_clr_i);
      overrun_q  <= overrun_set  || (overrun_q  && !flag_clr_i);
    end
  end

  assign pix_valid_o = (cnt_q != 5'd0);
  assign pix_o       = pix_valid_o ? pix_raw : '0;
  assign word_req_o  = word_req_q && !blank_i;
  assign underrun_o  = underrun_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pixel_shifter.sv
// tb_pixel_shifter: directed and randomized checks of pixel_shifter against a
// pixel-queue reference model.
module tb_pixel_shifter;

  logic        dotclk_i = 1'b0;
  logic        rst_ni;
  logic        load_i;
  logic [15:0] data_i;
  logic [1:0]  depth_i;
  logic [1:0]  stretch_i;
  logic        blank_i;
  logic        flag_clr_i;
  logic [7:0]  pix_o;
  logic        pix_valid_o;
  logic        word_req_o;
  logic        underrun_o;
  logic        overrun_o;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the current word becomes a queue of already-stretched
  // pixels; one entry is consumed per cycle.
  logic [7:0]  exp_q[$];
  logic [15:0] m_hold;
  logic        m_hold_full;
  logic        m_wreq;
  logic        m_under;
  logic        m_over;

  pixel_shifter #(.WORD_W(16), .PIX_W(8)) dut (
    .dotclk_i    (dotclk_i),
    .rst_ni      (rst_ni),
    .load_i      (load_i),
    .data_i      (data_i),
    .depth_i     (depth_i),
    .stretch_i   (stretch_i),
    .blank_i     (blank_i),
    .flag_clr_i  (flag_clr_i),
    .pix_o       (pix_o),
    .pix_valid_o (pix_valid_o),
    .word_req_o  (word_req_o),
    .underrun_o  (underrun_o),
    .overrun_o   (overrun_o)
  );

  // Clock
  always #5 dotclk_i = ~dotclk_i;

  function automatic void model_reset();
    exp_q.delete();
    m_hold      = '0;
    m_hold_full = 1'b0;
    m_wreq      = 1'b0;
    m_under     = 1'b0;
    m_over      = 1'b0;
  endfunction

  // One rising edge of the model, using the inputs the DUT sees at that edge.
  function automatic void model_step();
    logic        fin, xf, und, ovr;
    int          bpp, n;
    int unsigned v;
    if (blank_i) begin
      exp_q.delete();
      m_hold_full = 1'b0;
      m_wreq      = 1'b0;
      m_under     = m_under && !flag_clr_i;
      m_over      = m_over  && !flag_clr_i;
    end else begin
      fin = (exp_q.size() <= 1);
      xf  = fin && m_hold_full;
      und = (exp_q.size() == 1) && !m_hold_full;
      ovr = load_i && m_hold_full && !xf;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (xf) begin
        bpp = 1 << depth_i;
        n   = 16 / bpp;
        for (int i = 0; i < n; i++) begin
          v = (int'(m_hold) >> (16 - bpp * (i + 1))) & ((1 << bpp) - 1);
          for (int r = 0; r <= int'(stretch_i); r++) exp_q.push_back(8'(v));
        end
      end
      if (load_i && (!m_hold_full || xf)) begin
        m_hold      = data_i;
        m_hold_full = 1'b1;
      end else if (xf) begin
        m_hold_full = 1'b0;
      end
      m_wreq  = xf && !load_i;
      m_under = und || (m_under && !flag_clr_i);
      m_over  = ovr || (m_over  && !flag_clr_i);
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all();
    chk("pix_o", {8'h00, pix_o}, {8'h00, (exp_q.size() > 0) ? exp_q[0] : 8'h00});
    chk("pix_valid_o", {15'd0, pix_valid_o}, {15'd0, exp_q.size() > 0});
    chk("word_req_o", {15'd0, word_req_o}, {15'd0, m_wreq && !blank_i});
    chk("underrun_o", {15'd0, underrun_o}, {15'd0, m_under});
    chk("overrun_o", {15'd0, overrun_o}, {15'd0, m_over});
  endtask

  // Driver: one clock, model update at the edge, compare on the falling edge.
  task automatic tick();
    @(posedge dotclk_i);
    model_step();
    @(negedge dotclk_i);
    check_all();
  endtask

  task automatic drive(input logic ld, input logic [15:0] d);
    load_i = ld;
    data_i = d;
  endtask

  task automatic cfg(input logic [1:0] dep, input logic [1:0] str);
    depth_i   = dep;
    stretch_i = str;
  endtask

  task automatic clear_flags();
    flag_clr_i = 1'b1;
    tick();
    flag_clr_i = 1'b0;
  endtask

  initial begin
    int idx;
    logic [15:0] words [2];

    // Reset
    rst_ni = 1'b0; load_i = 1'b0; data_i = '0; depth_i = '0; stretch_i = '0;
    blank_i = 1'b0; flag_clr_i = 1'b0;
    model_reset();
    #12;
    check_all();
    rst_ni = 1'b1;

    // Two 8bpp words back-to-back, then underrun
    cfg(2'b11, 2'b00);
    drive(1'b1, 16'hA55A); tick();
    chk("t1_idle_valid", {15'd0, pix_valid_o}, 16'd0);
    drive(1'b1, 16'h1234); tick();
    chk("t1_pix0", {8'h00, pix_o}, 16'h00A5);
    drive(1'b0, 16'h0000); tick();
    chk("t1_pix1", {8'h00, pix_o}, 16'h005A);
    tick();
    chk("t1_pix2", {8'h00, pix_o}, 16'h0012);
    tick();
    chk("t1_pix3", {8'h00, pix_o}, 16'h0034);
    tick();
    chk("t1_underrun", {15'd0, underrun_o}, 16'd1);
    chk("t1_valid_low", {15'd0, pix_valid_o}, 16'd0);
    tick();
    clear_flags();

    // 1bpp stretched 2x
    cfg(2'b00, 2'b01);
    drive(1'b1, 16'h8001); tick();
    drive(1'b0, 16'h0000); tick();
    chk("t2_first", {8'h00, pix_o}, 16'h0001);
    chk("t2_wreq", {15'd0, word_req_o}, 16'd1);
    for (int i = 0; i < 33; i++) tick();
    clear_flags();

    // 4bpp continuous stream fed on word requests
    cfg(2'b10, 2'b00);
    words[0] = 16'h0123;
    words[1] = 16'h4567;
    drive(1'b1, words[0]); tick();
    idx = 1;
    drive(1'b0, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      if (m_wreq && idx < 2) begin
        drive(1'b1, words[idx]);
        idx++;
      end else begin
        drive(1'b0, 16'h0000);
      end
      tick();
    end
    chk("t3_no_overrun", {15'd0, overrun_o}, 16'd0);
    for (int i = 0; i < 3; i++) tick();
    clear_flags();

    // Overrun while hold full and shifter mid-word
    cfg(2'b11, 2'b11);
    drive(1'b1, 16'hAAAA); tick();
    drive(1'b1, 16'hBBBB); tick();
    drive(1'b1, 16'hFFFF); tick();
    chk("t4_overrun", {15'd0, overrun_o}, 16'd1);
    drive(1'b0, 16'h0000);
    for (int i = 0; i < 20; i++) tick();
    clear_flags();
    chk("t4_overrun_clr", {15'd0, overrun_o}, 16'd0);

    // Blank mid-word, then resume
    cfg(2'b01, 2'b00);
    drive(1'b1, 16'h5555); tick();
    drive(1'b0, 16'h0000); tick(); tick(); tick();
    blank_i = 1'b1;
    tick();
    chk("t5_blank_valid", {15'd0, pix_valid_o}, 16'd0);
    chk("t5_blank_pix", {8'h00, pix_o}, 16'h0000);
    blank_i = 1'b0;
    drive(1'b1, 16'hC000); tick();
    drive(1'b0, 16'h0000); tick();
    chk("t5_first", {8'h00, pix_o}, 16'h0003);
    for (int i = 0; i < 10; i++) tick();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) < 35, 16'($urandom));
      cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      blank_i    = ($urandom_range(0, 99) < 4);
      flag_clr_i = ($urandom_range(0, 99) < 5);
      tick();
    end
    blank_i = 1'b0; flag_clr_i = 1'b0;

    // Asynchronous reset between edges mid-stream
    cfg(2'b00, 2'b00);
    drive(1'b1, 16'hF0F0); tick();
    drive(1'b1, 16'h0F0F); tick(); tick();
    drive(1'b0, 16'h0000);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", {15'd0, pix_valid_o}, 16'd0);
    chk("rst_flags", {14'd0, underrun_o, overrun_o}, 16'd0);
    check_all();
    #1 rst_ni = 1'b1;
    cfg(2'b11, 2'b00);
    drive(1'b1, 16'h3C3C); tick();
    chk("rst_lat_edge1", {15'd0, pix_valid_o}, 16'd0);
    drive(1'b0, 16'h0000); tick();
    chk("rst_lat_edge2", {8'h00, pix_o}, 16'h003C);
    for (int i = 0; i < 4; i++) tick();

    // Report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
